// File: rtl/usb_tx_pkg.sv
// Shared USB TX/RX bit-level definitions: FSM states, stuffing run length, idle line level.
package usb_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STUFF = 2'd2
   } tx_state_e;

   // Same run length the receive-side unstuffer uses to drop a stuffed bit.
   localparam int   USB_RUN_LEN  = 6;
   localparam logic USB_IDLE_BIT = 1'b1;

endpackage

// File: rtl/usb_tx_bit_stuff_if.sv
// Byte handshake from the TX packet/CRC formatter into the bit stuffer.
interface usb_tx_bit_stuff_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] tx_data;
   logic              tx_last;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);

endinterface

// File: rtl/usb_tx_shifter.sv
// LSB-first byte shifter. Bit 0 leaves on the load strobe itself, so after a load
// the register holds the remaining DATA_W-1 bits and cur_bit is the next one out.
module usb_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic              cur_bit,
   output logic              empty
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] sr_q, sr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load) begin
         sr_d  = load_data >> 1;
         cnt_d = CW'(DATA_W - 1);
      end else if (shift && (cnt_q != '0)) begin
         sr_d  = sr_q >> 1;
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign cur_bit = sr_q[0];
   assign empty   = (cnt_q == '0);

endmodule

// File: rtl/usb_tx_bit_stuff.sv
// USB TX bit stuffer/serializer: one-byte holding register, IDLE/SEND/STUFF FSM, run counter.
// Optional TX_STUFF_STATS_EN adds a saturating per-packet stuffed-bit counter (stuff_count).
module usb_tx_bit_stuff
   import usb_tx_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int RUN_LEN = USB_RUN_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bit_strobe,
   usb_tx_bit_stuff_if.slave   tx_if,
   output logic                d_stuffed,
   output logic                d_valid,
   output logic                stuff_ins,
   output logic                tx_active,
   output logic                tx_done,
   output logic                tx_underrun
`ifdef TX_STUFF_STATS_EN
   ,
   output logic [15:0]         stuff_count
`endif
);

   localparam int RW = $clog2(RUN_LEN + 1);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              hold_last_q, hold_last_d;
   logic              cur_last_q, cur_last_d;
   logic [RW-1:0]     run_q, run_d;
   logic              d_stuffed_q, d_stuffed_d;
   logic              d_valid_q, d_valid_d;
   logic              stuff_ins_q, stuff_ins_d;
   logic              tx_active_q, tx_active_d;
   logic              tx_done_q, tx_done_d;
   logic              tx_underrun_q, tx_underrun_d;

   logic sh_load, sh_shift, sh_bit, sh_empty;
   logic emit, emit_bit, start, accept;

   usb_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (sh_load),
      .shift     (sh_shift),
      .load_data (hold_q),
      .cur_bit   (sh_bit),
      .empty     (sh_empty)
   );

   assign accept = tx_if.tx_valid & ~hold_full_q;

   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      hold_last_d   = hold_last_q;
      cur_last_d    = cur_last_q;
      run_d         = run_q;
      d_stuffed_d   = d_stuffed_q;
      d_valid_d     = 1'b0;
      stuff_ins_d   = 1'b0;
      tx_active_d   = tx_active_q;
      tx_done_d     = 1'b0;
      tx_underrun_d = 1'b0;
      sh_load       = 1'b0;
      sh_shift      = 1'b0;
      emit          = 1'b0;
      emit_bit      = 1'b0;
      start         = 1'b0;

      if (bit_strobe) begin
         case (state_q)
            IDLE: begin
               if (hold_full_q) begin
                  sh_load     = 1'b1;
                  emit        = 1'b1;
                  emit_bit    = hold_q[0];
                  cur_last_d  = hold_last_q;
                  tx_active_d = 1'b1;
                  start       = 1'b1;
               end
            end
            SEND: begin
               if (!sh_empty) begin
                  sh_shift = 1'b1;
                  emit     = 1'b1;
                  emit_bit = sh_bit;
               end else if (hold_full_q) begin
                  // Refill from hold on the same strobe so bytes run back-to-back.
                  sh_load    = 1'b1;
                  emit       = 1'b1;
                  emit_bit   = hold_q[0];
                  cur_last_d = hold_last_q;
               end else begin
                  tx_done_d     = cur_last_q;
                  tx_underrun_d = ~cur_last_q;
                  tx_active_d   = 1'b0;
                  d_stuffed_d   = USB_IDLE_BIT;
                  run_d         = '0;
                  state_d       = IDLE;
               end
            end
            STUFF: begin
               d_valid_d   = 1'b1;
               stuff_ins_d = 1'b1;
               d_stuffed_d = 1'b0;
               run_d       = '0;
               state_d     = SEND;
            end
            default: state_d = IDLE;
         endcase

         if (emit) begin
            d_valid_d   = 1'b1;
            d_stuffed_d = emit_bit;
            if (emit_bit) begin
               run_d   = run_q + RW'(1);
               state_d = ((run_q + RW'(1)) == RW'(RUN_LEN)) ? STUFF : SEND;
            end else begin
               run_d   = '0;
               state_d = SEND;
            end
         end
      end

      // A load this edge and a new acceptance never coincide: tx_ready was low.
      if (sh_load)
         hold_full_d = 1'b0;
      if (accept) begin
         hold_full_d = 1'b1;
         hold_d      = tx_if.tx_data;
         hold_last_d = tx_if.tx_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         hold_last_q   <= 1'b0;
         cur_last_q    <= 1'b0;
         run_q         <= '0;
         d_stuffed_q   <= USB_IDLE_BIT;
         d_valid_q     <= 1'b0;
         stuff_ins_q   <= 1'b0;
         tx_active_q   <= 1'b0;
         tx_done_q     <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         hold_last_q   <= hold_last_d;
         cur_last_q    <= cur_last_d;
         run_q         <= run_d;
         d_stuffed_q   <= d_stuffed_d;
         d_valid_q     <= d_valid_d;
         stuff_ins_q   <= stuff_ins_d;
         tx_active_q   <= tx_active_d;
         tx_done_q     <= tx_done_d;
         tx_underrun_q <= tx_underrun_d;
      end
   end

   assign tx_if.tx_ready = ~hold_full_q;
   assign d_stuffed      = d_stuffed_q;
   assign d_valid        = d_valid_q;
   assign stuff_ins      = stuff_ins_q;
   assign tx_active      = tx_active_q;
   assign tx_done        = tx_done_q;
   assign tx_underrun    = tx_underrun_q;

`ifdef TX_STUFF_STATS_EN
   logic [15:0] stuff_count_q, stuff_count_d;

   // Cleared at packet start, kept after tx_done so software can read it.
   always_comb begin
      stuff_count_d = stuff_count_q;
      if (start)
         stuff_count_d = '0;
      else if (bit_strobe && (state_q == STUFF) && (stuff_count_q != 16'hFFFF))
         stuff_count_d = stuff_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stuff_count_q <= '0;
      else
         stuff_count_q <= stuff_count_d;
   end

   assign stuff_count = stuff_count_q;
`endif

endmodule

// File: doc/usb_tx_bit_stuff.md
Name: usb_tx_bit_stuff

Overview:
USB transmit-path bit stuffer and serializer. Accepts packet bytes over a valid/ready handshake and shifts them out LSB-first, one bit per bit_strobe. After six consecutive 1s it inserts a 0. Sits between the TX packet/CRC formatter and the NRZI encoder, and is the counterpart of the receive-side bit unstuffer (same run length, same idle level).

Parameters:
DATA_W, 8, byte width on the input side
RUN_LEN, 6, number of consecutive 1s that forces one stuffed 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
bit_strobe  input  1  one-clock pulse per USB bit time (from TX bit-timing counter)
tx_data  input  DATA_W  byte to transmit, LSB first
tx_last  input  1  qualifies tx_data as the final byte of the packet
tx_valid  input  1  tx_data/tx_last valid
tx_ready  output  1  holding register empty; byte accepted on tx_valid & tx_ready
d_stuffed  output  1  serialized, stuffed bit stream to NRZI encoder
d_valid  output  1  pulses one clock when d_stuffed takes a new bit
stuff_ins  output  1  high with d_valid when the current bit is a stuffed 0
tx_active  output  1  packet in progress
tx_done  output  1  one-clock pulse at packet completion
tx_underrun  output  1  one-clock pulse; packet aborted because data starved

Behaviour:
- Reset (rst=1 at a clk edge): d_stuffed=1, d_valid=0, stuff_ins=0, tx_active=0, tx_done=0, tx_underrun=0, tx_ready=1, hold/shift registers empty, run count=0, state=IDLE. Reset mid-packet aborts silently with no tx_done and no tx_underrun.
- One-byte holding register. tx_ready = !hold_full. Acceptance sets hold_full and captures tx_last.
- Shift register holds the remaining bits of the current byte plus a bit counter 0..DATA_W.
- States: IDLE, SEND, STUFF.
- IDLE: d_stuffed=1; bit_strobe is ignored until hold_full. The first bit_strobe with hold_full moves hold into the shifter, emits bit0, sets tx_active and goes to SEND.
- SEND, on bit_strobe:
  - If the shifter has bits, emit the next LSB.
  - Else if hold_full, load it and emit bit0 in the same strobe, so back-to-back bytes have no gap.
  - Else if the last byte is done, pulse tx_done, clear tx_active, set d_stuffed=1 and go to IDLE.
  - Else pulse tx_underrun, set d_stuffed=1 and go to IDLE.
- Run counter (0..RUN_LEN): increments on every emitted 1 and clears on every emitted 0, including stuffed 0s. When an emitted 1 makes the count equal RUN_LEN, the next bit_strobe goes to STUFF.
- STUFF: the next bit_strobe emits 0 with stuff_ins=1, clears the run, returns to SEND and does not consume data.
- Stuffing applies across byte boundaries and after the final data bit. The trailing stuffed 0 is sent before tx_done.
- All outputs are registered.
  - d_stuffed, d_valid and stuff_ins update on the clock edge where bit_strobe=1.
  - Latency: a byte accepted at edge N produces its first bit no earlier than the first bit_strobe edge after N.
- tx_done and tx_underrun are mutually exclusive one-clock pulses, issued on the strobe after the final emitted bit.
- bit_strobe and tx_valid together on the same edge: the strobe decision uses hold contents from before that edge, and the acceptance lands in hold.
- bit_strobe held high continuously is legal: one bit per clock.

Optional Feature:
Macro TX_STUFF_STATS_EN.
- Defined: adds output stuff_count (16 bits), a count of stuffed bits.
  - Saturates at 0xFFFF.
  - Cleared by rst and at each IDLE to SEND transition.
  - Holds its value after tx_done.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package usb_tx_pkg: state enum (IDLE, SEND, STUFF), USB_RUN_LEN=6 (shared with the receive unstuffer), USB_IDLE_BIT=1'b1.
- One natural sub-module: usb_tx_shifter (DATA_W-bit load/shift register with bit counter and empty flag). FSM, run counter and holding register stay at the top level.

Test Plan:
- Single byte 0xA5 with tx_last, strobe every 8 clocks → d_valid bits 1,0,1,0,0,1,0,1, no stuff_ins, tx_done one strobe later, d_stuffed back to 1.
- 0xFF with tx_last → bits 1,1,1,1,1,1,0(stuff_ins),1,1: 9 d_valid pulses, then tx_done.
- Bytes 0xF0 then 0x03 (last), back-to-back → 0,0,0,0,1,1,1,1,1,1,0(stuff),0,0,0,0,0,0: 17 bits, no gap at the byte boundary, one stuff_ins.
- Byte 0x3F (last) → six 1s, then a trailing stuffed 0, then 0,0 (17? no: 1×6, stuff, 0,0 = 9 bits), then tx_done. Checks that stuffing after the final run precedes done.
- Non-last byte 0x00, then tx_valid withheld → 8 zeros, tx_underrun pulse, no tx_done, tx_active=0.
- rst asserted mid-byte of 0xFF,0xFF → next edge: all outputs at reset values, tx_ready=1, no done/underrun. A new packet afterwards transmits normally with the run count cleared.
